// File: rtl/fractal_frame_scheduler.sv
// Frame sequencer for the Mandelbrot divergence pipeline: issues one pixel per
// ISSUE_DIV cycles in raster order and writes each aligned result to the frame buffer.
module fractal_frame_scheduler #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int PIPE_DEPTH = 62,
  parameter int ISSUE_DIV  = 6,
  parameter int ADDR_W     = 19
) (
  input  logic              Clk_100M,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       startX,
  input  logic [15:0]       startY,
  input  logic [15:0]       stepX,
  input  logic [15:0]       stepY,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              pix_valid,
  output logic              pix_no_op,
  input  logic [7:0]        res_div,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_din,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        state_dbg
);

  // Handshake: start is honoured only in IDLE; busy spans acceptance to frame_done,
  // pix_valid and fb_we are single-cycle qualifiers with no back-pressure.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DIV_W = (ISSUE_DIV > 1) ? $clog2(ISSUE_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ISSUE_DIV - 1);
  localparam logic [15:0]       COL_LAST  = 16'(H_RES - 1);
  localparam logic [15:0]       ROW_LAST  = 16'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);

  state_t state_q, state_d;

  logic [15:0]           start_x_q, step_x_q, step_y_q;
  logic [15:0]           col_q, row_q;
  logic [DIV_W-1:0]      divcnt_q, div_next;
  logic [PIPE_DEPTH-1:0] vld_pipe;
  logic [ADDR_W-1:0]     wr_cnt;
  logic                  issue_now, last_pix, last_wr, vld_tap;

  assign vld_tap   = vld_pipe[PIPE_DEPTH-1];
  assign pix_no_op = ~pix_valid;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d   = state_q;
    issue_now = (state_q == ISSUE) && (divcnt_q == '0);
    last_pix  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    last_wr   = fb_we && (fb_addr == ADDR_LAST);
    div_next  = (divcnt_q == DIV_LAST) ? '0 : divcnt_q + 1'b1;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (issue_now && last_pix) state_d = DRAIN;
      DRAIN:   if (last_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // pix_x/pix_y double as the running coordinate: they are loaded on the edge
  // that opens each issue cycle and hold until the next one.
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      start_x_q  <= '0;
      step_x_q   <= '0;
      step_y_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      divcnt_q   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_valid  <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            start_x_q <= startX;
            step_x_q  <= stepX;
            step_y_q  <= stepY;
            col_q     <= '0;
            row_q     <= '0;
            divcnt_q  <= '0;
            pix_x     <= startX;
            pix_y     <= startY;
            pix_valid <= 1'b1;
          end
        end
        ISSUE: begin
          divcnt_q <= div_next;
          if (!(issue_now && last_pix) && (div_next == '0)) begin
            pix_valid <= 1'b1;
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + 16'd1;
              pix_x <= start_x_q;
              pix_y <= pix_y + step_y_q;
            end else begin
              col_q <= col_q + 16'd1;
              pix_x <= pix_x + step_x_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Token delay line: the tap rises PIPE_DEPTH cycles after an issue, exactly when
  // that pixel's result sits on res_div; the write lands one cycle later.
  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      vld_pipe   <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_din     <= '0;
      wr_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      vld_pipe[0] <= pix_valid;
      for (int i = 1; i < PIPE_DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
      fb_we      <= vld_tap;
      frame_done <= 1'b0;
      if (vld_tap) begin
        fb_din  <= res_div;
        fb_addr <= wr_cnt;
        wr_cnt  <= wr_cnt + 1'b1;
      end
      if ((state_q == DRAIN) && last_wr) begin
        frame_done <= 1'b1;
        wr_cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fractal_frame_scheduler.sv
// Directed bench for fractal_frame_scheduler: reset/idle on the default build,
// raster issue, latency alignment, wrap, handshake and abort on a 4x3 build.
module tb_fractal_frame_scheduler;

  localparam int H = 4, V = 3, PD = 5, DIV = 2, AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start;
  logic [15:0]   sx, sy, dx, dy;
  logic [7:0]    res_div;
  logic [15:0]   pix_x, pix_y;
  logic          pix_valid, pix_no_op, fb_we, busy, frame_done;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_din;
  logic [1:0]    state_dbg;

  logic          b_start;
  logic [7:0]    b_res_div;
  logic [15:0]   b_pix_x, b_pix_y;
  logic          b_pix_valid, b_pix_no_op, b_fb_we, b_busy, b_frame_done;
  logic [18:0]   b_fb_addr;
  logic [7:0]    b_fb_din;
  logic [1:0]    b_state_dbg;

  fractal_frame_scheduler #(.H_RES(H), .V_RES(V), .PIPE_DEPTH(PD), .ISSUE_DIV(DIV), .ADDR_W(AW)) u_dut (
    .Clk_100M(clk), .reset(reset), .start(start),
    .startX(sx), .startY(sy), .stepX(dx), .stepY(dy),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_no_op(pix_no_op),
    .res_div(res_div), .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  fractal_frame_scheduler u_dut_dflt (
    .Clk_100M(clk), .reset(reset), .start(b_start),
    .startX(16'h0000), .startY(16'h0000), .stepX(16'h0001), .stepY(16'h0001),
    .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_valid(b_pix_valid), .pix_no_op(b_pix_no_op),
    .res_div(b_res_div), .fb_we(b_fb_we), .fb_addr(b_fb_addr), .fb_din(b_fb_din),
    .busy(b_busy), .frame_done(b_frame_done), .state_dbg(b_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_issue, n_wr;
  logic [15:0] cap_x[4];
  logic [15:0] last_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    res_div = 8'(cyc);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
    check({tag, "_noop"},  {31'd0, pix_no_op}, 32'd1);
    check({tag, "_we"},    {31'd0, fb_we}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, frame_done}, 32'd0);
  endtask

  // The current interval becomes cycle 0 (start high). With hold=1 start stays
  // high through frame_done so the caller can chain the next frame immediately.
  task automatic run_frame(input logic [15:0] x0, input logic [15:0] y0,
                           input logic [15:0] ddx, input logic [15:0] ddy, input bit hold);
    logic [31:0] e;
    bit exp_v, exp_we;
    exp_q.delete();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        exp_q.push_back({16'(y0 + r * ddy), 16'(x0 + c * ddx)});
    sx = x0; sy = y0; dx = ddx; dy = ddy;
    start = 1'b1;
    cyc = 0;
    res_div = 8'd0;
    n_issue = 0;
    n_wr = 0;
    check("busy_c0", {31'd0, busy}, 32'd0);
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = hold;
      sx = 16'($urandom); sy = 16'($urandom);
      dx = 16'($urandom); dy = 16'($urandom);
      exp_v  = (c % 2 == 1) && (c <= 23);
      exp_we = (c % 2 == 1) && (c >= 7) && (c <= 29);
      check("pix_valid", {31'd0, pix_valid}, {31'd0, exp_v});
      check("pix_no_op", {31'd0, pix_no_op}, {31'd0, ~exp_v});
      check("fb_we", {31'd0, fb_we}, {31'd0, exp_we});
      check("frame_done", {31'd0, frame_done}, {31'd0, c == 30});
      check("busy", {31'd0, busy}, {31'd0, c < 30});
      if (pix_valid) begin
        if (n_issue < 4) cap_x[n_issue] = pix_x;
        last_y = pix_y;
        n_issue++;
        if (exp_q.size() == 0) check("pix_extra", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("pix_xy", {pix_y, pix_x}, e);
        end
      end
      if (fb_we) begin
        n_wr++;
        check("fb_addr", 32'(fb_addr), 32'((c - 7) / 2));
        check("fb_din", {24'd0, fb_din}, {24'd0, 8'(c - 1)});
      end
    end
    check("n_issue", n_issue, 12);
    check("n_wr", n_wr, 12);
    if (!hold) begin
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick();
        check_quiet("post");
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; b_start = 1'b0; b_res_div = 8'd0;
    sx = '0; sy = '0; dx = '0; dy = '0; res_div = '0;

    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_valid", {31'd0, b_pix_valid}, 32'd0);
      check("rst_noop", {31'd0, b_pix_no_op}, 32'd1);
      check_quiet("rst_small");
    end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_valid", {31'd0, b_pix_valid}, 32'd0);
      check("idle_noop", {31'd0, b_pix_no_op}, 32'd1);
      check("idle_we", {31'd0, b_fb_we}, 32'd0);
      check("idle_busy", {31'd0, b_busy}, 32'd0);
      check("idle_done", {31'd0, b_frame_done}, 32'd0);
    end

    run_frame(16'h1000, 16'h2000, 16'h0010, 16'h0020, 1'b0);
    check("col3_x", {16'd0, cap_x[3]}, 32'h1030);
    check("last_y", {16'd0, last_y}, 32'h2040);

    run_frame(16'hFFF0, 16'h0000, 16'h0010, 16'h0001, 1'b0);
    check("wrap_x0", {16'd0, cap_x[0]}, 32'hFFF0);
    check("wrap_x1", {16'd0, cap_x[1]}, 32'h0000);
    check("wrap_x2", {16'd0, cap_x[2]}, 32'h0010);
    check("wrap_x3", {16'd0, cap_x[3]}, 32'h0020);

    run_frame(16'h1000, 16'h2000, 16'h0010, 16'h0020, 1'b1);
    run_frame(16'h0100, 16'h0200, 16'h0001, 16'h0001, 1'b0);

    // abort: reset lands at cycle 15 of a frame
    sx = 16'h1000; sy = 16'h2000; dx = 16'h0010; dy = 16'h0020;
    start = 1'b1; cyc = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      check_quiet("abort");
    end
    run_frame(16'h3000, 16'h4000, 16'h0002, 16'h0003, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fractal_frame_scheduler.md
Name: fractal_frame_scheduler

Overview:
Sequences one full frame of the Mandelbrot divergence pipeline. On a start request it latches the view window (startX/startY/stepX/stepY), issues one pixel coordinate into pipeline stage 0 every ISSUE_DIV cycles in raster order, and tags each issue with a validity token. When the matching result leaves the last stage it is written into the frame buffer at the pixel's linear address. Replaces the free-running column/row counters in the top level and adds start/busy/done handshaking plus exact latency alignment.

Parameters:
H_RES, 640, pixels per row
V_RES, 480, rows per frame
PIPE_DEPTH, 62, cycles from stage-0 input to last-stage output (one cycle per diverge_pipe stage)
ISSUE_DIV, 6, cycles between consecutive issues (must be >=1)
ADDR_W, 19, frame-buffer address width (must satisfy 2^ADDR_W >= H_RES*V_RES)

Ports:
Clk_100M  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  frame request; sampled only in IDLE
startX  in  16  top-left real coordinate; latched on accepted start
startY  in  16  top-left imaginary coordinate; latched on accepted start
stepX  in  16  horizontal step; latched on accepted start
stepY  in  16  vertical step; latched on accepted start
pix_x  out  16  stage-0 x and c1
pix_y  out  16  stage-0 y and c2
pix_valid  out  1  one-cycle pulse: pix_x/pix_y hold a new pixel
pix_no_op  out  1  stage-0 no_op flag; equals ~pix_valid
res_div  in  8  divergence count from last pipeline stage
fb_we  out  1  frame-buffer write enable
fb_addr  out  ADDR_W  write address = row*H_RES + col
fb_din  out  8  write data
busy  out  1  high from start acceptance until frame_done
frame_done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset: state=IDLE; all outputs 0, except pix_no_op=1; the token delay line, counters and latched window are cleared. Reset mid-frame aborts immediately: no further issues, writes or frame_done. In-flight tokens are discarded.
- States are IDLE, ISSUE and DRAIN.
- IDLE: when start=1, latch the window, set col=0, row=0, cur_x=startX, cur_y=startY and divcnt=0. Go to ISSUE. busy=1 from the next cycle.
- ISSUE: divcnt counts 0..ISSUE_DIV-1 and wraps. Issue occurs on each cycle with divcnt==0:
  - the first issue is the cycle after acceptance;
  - registered outputs pix_x=cur_x, pix_y=cur_y, pix_valid=1 for that cycle only;
  - pix_x/pix_y hold their values between issues.
- Coordinate advance after each issue, all 16-bit modulo-2^16 adds with no saturation and no multipliers:
  - col<H_RES-1: col+1, cur_x+=stepX;
  - col==H_RES-1: col=0, cur_x=startX, row+1, cur_y+=stepY.
- After the issue with row==V_RES-1 and col==H_RES-1, go to DRAIN. No further pix_valid pulses occur.
- Token alignment:
  - a 1-bit valid delay line of length PIPE_DEPTH is fed by pix_valid;
  - when its output is 1 (cycle t+PIPE_DEPTH for an issue at t), res_div is sampled;
  - next cycle (t+PIPE_DEPTH+1): fb_we=1, fb_din=sampled value, fb_addr=wr_cnt; then wr_cnt+1.
  - Raster order is preserved, so wr_cnt equals the pixel's linear address.
  - fb_we is a one-cycle pulse per pixel.
- DRAIN: wait for the write with wr_cnt==H_RES*V_RES-1. In the cycle after that write: frame_done=1 for one cycle, busy=0, state=IDLE, wr_cnt=0.
- start while busy is ignored; window inputs may change freely once latched.
- start asserted in the cycle frame_done is high is accepted, since the state is IDLE.
- ISSUE_DIV==1: issues on consecutive cycles.
- PIPE_DEPTH>ISSUE_DIV: multiple tokens in flight are legal.
- Total frame latency from acceptance to frame_done: (H_RES*V_RES-1)*ISSUE_DIV + PIPE_DEPTH + 3 cycles.

Test Plan:
- Reset/idle (default params): hold reset 3 cycles, then idle 20 cycles -> pix_valid=fb_we=busy=frame_done=0, pix_no_op=1 throughout.
- Small frame (H_RES=4, V_RES=3, PIPE_DEPTH=5, ISSUE_DIV=2), startX=0x1000, startY=0x2000, stepX=0x0010, stepY=0x0020, start pulse at cycle 0 -> 12 pix_valid pulses at cycles 1,3,...,23. Pixel (col=3,row=0) has pix_x=0x1030. Pixel (0,1) has pix_x=0x1000, pix_y=0x2020. Last pixel has pix_y=0x2040. Every issue has pix_no_op=0.
- Alignment, same config, res_div driven = low 8 bits of cycle count -> fb_we at cycles 7,9,...,29 with fb_addr 0..11 and fb_din = value at cycle-1. frame_done at cycle 30 (22+5+3). busy falls at cycle 30.
- Wrap: startX=0xFFF0, stepX=0x0010, H_RES=4 -> pix_x sequence 0xFFF0, 0x0000, 0x0010, 0x0020 with no saturation.
- Handshake: start pulsed mid-frame -> ignored, 12 writes exactly. start held high through frame_done -> second frame begins the following cycle with addresses restarting at 0.
- Abort: reset at cycle 15 of the small frame -> no fb_we after reset, no frame_done. A new start then gives a full 12-write frame from addr 0.
